// File: rtl/shift_deserializer_if.sv
// shift_deserializer_if: serial-in / word-out bus between a bit source, the deserializer and its consumer.
interface shift_deserializer_if #(parameter int WIDTH = 8, parameter int CNT_W = 4);
  logic serial_in;
  logic shift_en;
  logic frame_start;
  logic data_ready;
  logic overrun_clr;
  logic [WIDTH-1:0] data_out;
  logic data_valid;
  logic overrun;
  logic parity_err;
  logic [CNT_W-1:0] bit_count;
  modport master (
    output serial_in, shift_en, frame_start, data_ready, overrun_clr,
    input data_out, data_valid, overrun, parity_err, bit_count
  );
  modport slave (
    input serial_in, shift_en, frame_start, data_ready, overrun_clr,
    output data_out, data_valid, overrun, parity_err, bit_count
  );
endinterface

// File: rtl/shift_deserializer.sv
// shift_deserializer: LSB-first serial-to-parallel receiver with a one-entry valid/ready holding register.
// Define SHIFT_DESERIALIZER_PARITY_EN to expect a trailing even-parity bit per word.
module shift_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic reset,
  shift_deserializer_if.slave bus
);
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] sr, sr_base, sr_nx, shifted, word, data_q;
  logic [CNT_W-1:0] cnt, cnt_base, cnt_nx;
  logic valid_q, ovr_q, perr_q, par, complete, free, take;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = bus.shift_en ? (complete ? IDLE : RECV) : (bus.frame_start ? IDLE : state);
  // frame_start restarts the word on this same edge, so the strobe it accompanies counts as bit 0
  always_comb begin
    cnt_base = (state == IDLE || bus.frame_start) ? '0 : cnt;
    complete = bus.shift_en && cnt_base == CNT_W'(FRAME_BITS - 1);
  end
  always_comb begin
    sr_base = bus.frame_start ? '0 : sr;
    shifted = {bus.serial_in, sr_base[WIDTH-1:1]};
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    word = sr_base;
    par = ^sr_base ^ bus.serial_in;
    sr_nx = complete ? '0 : (bus.shift_en && cnt_base < CNT_W'(WIDTH)) ? shifted : sr_base;
`else
    word = shifted;
    par = 1'b0;
    sr_nx = complete ? '0 : bus.shift_en ? shifted : sr_base;
`endif
    cnt_nx = complete ? '0 : bus.shift_en ? cnt_base + 1'b1 : cnt_base;
    free = !valid_q || bus.data_ready;
    take = valid_q && bus.data_ready;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sr <= '0;
      cnt <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      sr <= sr_nx;
      cnt <= cnt_nx;
      if (complete && free) begin
        data_q <= word;
        valid_q <= 1'b1;
        perr_q <= par;
      end else if (take) begin
        valid_q <= 1'b0;
        perr_q <= 1'b0;
      end
      ovr_q <= (complete && !free) || (ovr_q && !bus.overrun_clr);
    end
  assign bus.data_out = data_q;
  assign bus.data_valid = valid_q;
  assign bus.overrun = ovr_q;
  assign bus.parity_err = perr_q;
  assign bus.bit_count = cnt;
endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
- Receive-side counterpart of the team's 8-bit right-shifting parallel-load shifter.
- Captures the LSB-first serial stream that shifter emits on q[0], one bit per shift strobe, and reassembles WIDTH-bit words.
- Each completed word is presented on a one-entry holding register with a valid/ready handshake; a lost word raises a sticky overrun flag.
- Sits between a serial link (or the shifter's q[0] in loopback) and a parallel consumer.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > WIDTH (+1 when parity is compiled in).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- serial_in, input, 1, serial data bit; sampled only when shift_en=1.
- shift_en, input, 1, bit strobe; one bit captured per cycle it is high.
- frame_start, input, 1, synchronous resync; discards any partial word.
- data_out, output, WIDTH, last completed word (holding register).
- data_valid, output, 1, holding register contains an unconsumed word.
- data_ready, input, 1, consumer accepts data_out when data_valid=1 at the clk edge.
- overrun, output, 1, sticky: a completed word was dropped.
- overrun_clr, input, 1, synchronous clear of overrun.
- bit_count, output, CNT_W, number of bits of the current partial word received.
- parity_err, output, 1, parity result qualified by data_valid (0 when feature absent).

Behaviour:
- Reset (asynchronous, immediate): shift register=0, bit_count=0, data_out=0, data_valid=0, overrun=0, parity_err=0, state=IDLE.
- States:
  - IDLE: bit_count=0, no partial word.
  - RECV: 0 < bit_count < FRAME_BITS.
  - FRAME_BITS = WIDTH, or WIDTH+1 with parity compiled in.
- Shift: on a clk edge with shift_en=1, sr <= {serial_in, sr[WIDTH-1:1]}. The first bit received ends in bit 0, matching the transmitter's right-shift order. bit_count increments.
- State transitions:
  - IDLE→RECV on the first shift.
  - RECV→IDLE on the shift that brings bit_count to FRAME_BITS; that same edge sets bit_count to 0.
- Word completion (same edge as the last shift, latency 0 cycles after the final strobe):
  - If the holding register is free (data_valid=0, or data_valid=1 with data_ready=1 on this edge): data_out <= assembled word including the bit just shifted in, and data_valid <= 1.
  - Otherwise: data_out is unchanged, the new word is discarded, and overrun <= 1.
- Handshake:
  - data_valid=1 and data_ready=1 at an edge with no completion: data_valid <= 0; data_out holds its value.
  - data_ready is ignored while data_valid=0.
  - data_valid never drops without a handshake, except on reset.
- frame_start=1: bit_count <= 0 and sr <= 0, and the partial word is discarded; the holding register and data_valid are unaffected.
  - If shift_en is also 1, the sampled bit becomes bit 0 of the new word: bit_count=1, state=RECV.
- overrun_clr and a new overrun event on the same edge: set wins, overrun=1.
- shift_en held high continuously is legal: one word every FRAME_BITS cycles, back-to-back, with no idle bubble.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SHIFT_DESERIALIZER_PARITY_EN.
- Defined:
  - FRAME_BITS = WIDTH+1. The final bit is an even-parity bit over the WIDTH data bits and is not stored in data_out.
  - parity_err <= XOR(data bits, parity bit) and is loaded together with data_out. It is dropped with the word on overrun.
- Undefined:
  - FRAME_BITS = WIDTH and parity_err is tied to 0.
  - The port remains in both builds.

Test Plan:
- Reset mid-word: after 3 shifts (bit_count=3), pulse reset → bit_count=0, data_valid=0, data_out=0 immediately, without waiting for a clk edge.
- Basic word: shift in bits 1,0,1,0,0,1,0,1 on consecutive strobes with gaps, data_ready=0 → after the 8th strobe edge data_out=0xA5, data_valid=1, bit_count=0. Then set data_ready=1 for one cycle → data_valid=0 and data_out stays 0xA5.
- Overrun: receive 0x3C and leave it unconsumed, then receive 0xFF → data_out=0x3C and overrun=1. Pulse overrun_clr → overrun=0.
- Back-to-back with ready held at 1: continuous shift_en for 16 cycles carrying 0x81 then 0x7E → data_valid is high on cycle 8 (0x81) and on cycle 16 (0x7E), and overrun stays 0.
- Resync: after 5 bits, assert frame_start together with shift_en and serial_in=1, then send 7 more bits of 0x55's upper bits (0,1,0,1,0,1,0) → data_out=0x55 and bit_count=1 immediately after the frame_start edge.
- Parity (with macro): send 0xA5 followed by parity bit 0 → parity_err=0. Send 0xA5 followed by parity bit 1 → parity_err=1. In both cases data_out=0xA5.
